// File: rtl/traffic_accumulator_pkg.sv
// Shared types and sizes for the per-hour traffic accumulator.
// Also carries the saturating increment used by the hour counter.
package traffic_accumulator_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

  localparam int NUM_HOURS = 24;
  localparam int CNT_W     = 10;
  localparam int HOUR_W    = 5;

  typedef enum logic [2:0] {
    INIT,
    COUNT,
    COMMIT,
    NOTIFY,
    CLEAR
  } acc_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] val,
    input logic             inc,
    input logic [CNT_W-1:0] lim
  );
    if (inc && val != lim) return val + CNT_W'(1);
    return val;
  endfunction

endpackage

// File: rtl/traffic_accumulator_sensor_debounce.sv
// Sensor front end: two-flop synchroniser, rising-edge detect and
// holdoff window; emits a one-cycle pulse per accepted vehicle.
module traffic_accumulator_sensor_debounce #(
  parameter int HOLDOFF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor,
  output logic pulse
);

  localparam int HW = $clog2(HOLDOFF + 1);

  logic          s1;
  logic          s2;
  logic          s3;
  logic [HW-1:0] hold;
  logic          rise;

  assign rise  = s2 & ~s3;
  assign pulse = rise & (hold == '0);

  // Synchroniser chain plus one stage of history for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Holdoff window: reload on acceptance, count down to zero otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (pulse) begin
      hold <= HW'(HOLDOFF - 1);
    end else if (hold != '0) begin
      hold <= hold - HW'(1);
    end
  end

endmodule

// File: rtl/traffic_accumulator.sv
// Counts debounced vehicles per hour, commits each hour into a 24-entry
// table, runs the OP1/OP2 handshake to the ranker and clears daily.
module traffic_accumulator
  import traffic_accumulator_pkg::*;
#(
  parameter int HOLDOFF     = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_MAX     = 1023
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            SENSOR_IN,
  input  logic [HOUR_W-1:0]               HOUR,
  input  logic [5:0]                      MINUTE,
  input  logic [5:0]                      SECOND,
  input  op_t                             OP2,
  output logic [NUM_HOURS-1:0][CNT_W-1:0] TRAFFIC_DATA,
  output op_t                             OP1,
  output logic                            SAT_FLAG,
  output logic                            ACK_ERR
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LIM  = CNT_W'(CNT_MAX);
  localparam logic [HOUR_W-1:0] LAST = HOUR_W'(NUM_HOURS - 1);

  acc_state_t        state;
  acc_state_t        nstate;
  logic              evt;
  logic              counting;
  logic              hour_chg;
  logic              ack;
  logic              timeout;
  logic              notify_exit;
  logic              load;
  logic              drop;
  logic              sat_hit;
  logic [HOUR_W-1:0] prev_hour;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  snap;
  logic [HOUR_W-1:0] commit_hour;
  logic [CNT_W-1:0]  commit_val;
  logic              pending;
  logic [HOUR_W-1:0] pend_hour;
  logic [CNT_W-1:0]  pend_val;
  logic [TW-1:0]     timer;
  logic              time_unused;

  // Wall-clock minutes/seconds are informational only.
  assign time_unused = ^{MINUTE, SECOND};

  traffic_accumulator_sensor_debounce #(
    .HOLDOFF(HOLDOFF)
  ) u_debounce (
    .clk   (CLK),
    .rst_n (RST_N),
    .sensor(SENSOR_IN),
    .pulse (evt)
  );

  assign counting    = (state != INIT);
  assign hour_chg    = counting && (HOUR != prev_hour);
  assign snap        = sat_inc(acc, evt && counting, LIM);
  assign sat_hit     = counting && evt && (acc == LIM);
  assign ack         = (OP2 == WRITE);
  assign timeout     = (timer == TW'(ACK_TIMEOUT - 1));
  assign notify_exit = (state == NOTIFY) && (ack || timeout);
  assign load        = (nstate == COMMIT);
  assign drop        = hour_chg && pending && !load;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= INIT;
    else        state <= nstate;
  end

  // Next-state logic; a queued commit runs as soon as the FSM is free.
  always_comb begin
    nstate = state;
    unique case (state)
      INIT:   nstate = COUNT;
      COUNT:  if (hour_chg || pending) nstate = COMMIT;
      COMMIT: nstate = NOTIFY;
      NOTIFY: begin
        if (notify_exit) begin
          if (commit_hour == LAST) nstate = CLEAR;
          else if (pending)        nstate = COMMIT;
          else                     nstate = COUNT;
        end
      end
      CLEAR:  nstate = pending ? COMMIT : COUNT;
      default: nstate = INIT;
    endcase
  end

  // Handshake output: request a ranker read for the whole NOTIFY stay.
  always_comb begin
    OP1 = (state == NOTIFY) ? READ : WRITE;
  end

  // Hour tracking: seeded in INIT, followed on every detected change.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      prev_hour <= '0;
    end else if (state == INIT || hour_chg) begin
      prev_hour <= HOUR;
    end
  end

  // Running count for the current hour; restarts at each hour change.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc <= '0;
    end else if (hour_chg) begin
      acc <= '0;
    end else if (counting) begin
      acc <= snap;
    end
  end

  // Commit staging and the one-deep queue for changes seen while busy.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      commit_hour <= '0;
      commit_val  <= '0;
      pending     <= 1'b0;
      pend_hour   <= '0;
      pend_val    <= '0;
    end else begin
      if (load) begin
        if (pending) begin
          commit_hour <= pend_hour;
          commit_val  <= pend_val;
        end else begin
          commit_hour <= prev_hour;
          commit_val  <= snap;
        end
      end
      if (hour_chg && (pending ? load : !load)) begin
        pending   <= 1'b1;
        pend_hour <= prev_hour;
        pend_val  <= snap;
      end else if (load && pending) begin
        pending <= 1'b0;
      end
    end
  end

  // Ack timer: clocks spent in NOTIFY without a ranker response.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      timer <= '0;
    end else if (state == NOTIFY && !notify_exit) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= '0;
    end
  end

  // Per-hour table: one entry per COMMIT, wiped in CLEAR.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      TRAFFIC_DATA <= '0;
    end else if (state == CLEAR) begin
      TRAFFIC_DATA <= '0;
    end else if (state == COMMIT) begin
      TRAFFIC_DATA[commit_hour] <= commit_val;
    end
  end

  // Saturation flag: daily sticky, a fresh saturation wins over CLEAR.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      SAT_FLAG <= 1'b0;
    end else if (sat_hit) begin
      SAT_FLAG <= 1'b1;
    end else if (state == CLEAR) begin
      SAT_FLAG <= 1'b0;
    end
  end

  // Error flag: abandoned handshakes and dropped hour commits.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ACK_ERR <= 1'b0;
    end else if (drop || (state == NOTIFY && !ack && timeout)) begin
      ACK_ERR <= 1'b1;
    end
  end

endmodule

// File: doc/traffic_accumulator.md
Name: traffic_accumulator

Overview:
- Upstream stage that feeds the rank calculator.
- Synchronises and debounces a raw vehicle-sensor line and counts events for the current hour.
- On each hour change it commits the count into a 24-entry per-hour traffic table and drives the OP1/OP2 handshake so the ranker samples the table.
- Clears the table once per day after the 23→0 commit has been acknowledged.

Parameters:
- HOLDOFF, 4, minimum clocks between two accepted sensor events; closer edges are dropped.
- ACK_TIMEOUT, 16, clocks OP1 is held at READ without OP2==WRITE before the handshake is abandoned.
- CNT_MAX, 1023, saturation value of each 10-bit hour count.

Ports:
- CLK  in  1  system clock; the only clock.
- RST_N  in  1  reset, synchronous, active-low.
- SENSOR_IN  in  1  raw asynchronous sensor line; a rising edge is one vehicle.
- HOUR  in  5  current hour, 0..23.
- MINUTE  in  6  current minute (informational; not used for boundary detection).
- SECOND  in  6  current second (informational).
- OP2  in  op_t  ranker response; WRITE means the ranked data was produced.
- TRAFFIC_DATA  out  24x10  committed per-hour counts, indexed by hour.
- OP1  out  op_t  READ requests the ranker to sample TRAFFIC_DATA; WRITE means idle.
- SAT_FLAG  out  1  sticky; some count saturated today.
- ACK_ERR  out  1  sticky; a handshake timed out or a commit was lost.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - All TRAFFIC_DATA = 0, accumulator = 0, OP1 = WRITE, SAT_FLAG = 0, ACK_ERR = 0.
  - State = INIT; holdoff counter = 0; pending = 0.
  - Reset mid-handshake abandons the handshake silently.
- INIT: captures HOUR into prev_hour for one cycle, then goes to COUNT. No commit is generated at startup.
- Sensor path:
  - Two-flop synchroniser, then rising-edge detect.
  - An edge is accepted only when the holdoff counter is 0. Acceptance reloads the counter with HOLDOFF-1.
  - An accepted edge increments the accumulator 3 clocks after the SENSOR_IN rise.
  - The accumulator saturates at CNT_MAX. An increment attempted at CNT_MAX sets SAT_FLAG.
  - Counting continues in every state except INIT.
- Hour change: detected when HOUR != prev_hour.
  - prev_hour is updated on the detect cycle.
  - An event accepted in the detect cycle belongs to the old hour.
- COMMIT (1 cycle):
  - TRAFFIC_DATA[old hour] <= accumulator (including any same-cycle event, saturated).
  - Accumulator <= 0.
  - Next state NOTIFY.
- NOTIFY:
  - OP1 = READ from the cycle after COMMIT.
  - OP1 stays READ until OP2==WRITE is sampled; OP1 returns to WRITE on the following edge.
  - If ACK_TIMEOUT clocks pass without OP2==WRITE: set ACK_ERR and leave NOTIFY with OP1 = WRITE.
  - Exit goes to CLEAR if the committed hour was 23, otherwise to COUNT.
- CLEAR (1 cycle):
  - All 24 TRAFFIC_DATA entries <= 0; SAT_FLAG <= 0.
  - The accumulator (already counting hour 0) is untouched.
  - Next state COUNT.
- Hour change while in COMMIT/NOTIFY/CLEAR:
  - Latch pending = 1 with the old hour and the accumulator snapshot.
  - Execute a COMMIT immediately on return to COUNT.
  - A second change while pending is set is dropped and sets ACK_ERR.
- Skipped hours (HOUR jumps by more than 1): only the previous hour is written. Other entries are unchanged.
- Arithmetic: all counts are unsigned 10-bit; no wrap-around anywhere.

Decomposition:
- Shared system package:
  - op_t (READ, WRITE) is the existing type, reused unchanged.
  - New: NUM_HOURS = 24, CNT_W = 10, HOUR_W = 5.
  - New: acc_state_t {INIT, COUNT, COMMIT, NOTIFY, CLEAR}.
- One natural sub-module: sensor_debounce (synchroniser, edge detect, holdoff counter), producing a one-cycle event pulse.

Test Plan:
- Reset, HOUR=5, 7 clean sensor pulses spaced 10 clks, HOUR→6 → TRAFFIC_DATA[5]=7; OP1=READ next cycle; bench drives OP2=WRITE 1 clk later → OP1=WRITE the following cycle.
- Two SENSOR_IN rises 2 clks apart (HOLDOFF=4) → count +1 only. Rises 4 clks apart → +2.
- Drive 1030 events within hour 9, then HOUR→10 → TRAFFIC_DATA[9]=1023; SAT_FLAG=1 until the next CLEAR.
- Hold OP2=READ after a commit → OP1=READ for 16 clks, then WRITE; ACK_ERR=1; counting is uninterrupted.
- HOUR 23→0 with 3 events in hour 23 → TRAFFIC_DATA[23]=3 visible during NOTIFY; after ack all 24 entries = 0; an event in the CLEAR cycle counts into hour 0.
- Event in the same cycle as the HOUR change, plus a second HOUR change during NOTIFY → event lands in the old hour; pending commit executes right after NOTIFY; RST_N low mid-NOTIFY → OP1=WRITE and table zeroed on that edge.
